// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point ALU pipeline: op encodings and
// default Q-format split.
package fxp_pkg;

  localparam int unsigned DEF_INT_BITS  = 8;
  localparam int unsigned DEF_FRAC_BITS = 8;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_MAC     = 3'b011;
  localparam logic [2:0] OP_ACC_CLR = 3'b100;
  localparam logic [2:0] OP_ACC_RD  = 3'b101;

endpackage

// File: rtl/fxp_sat.sv
// Signed saturating narrower: clamps a wide signed value into W bits.
// Ports:
//   din    - signed value, IN_W bits (IN_W >= W)
//   dout_c - clamped value, W bits (combinational)
//   sat_c  - 1 when din was outside the W-bit signed range (combinational)
module fxp_sat #(
  parameter int unsigned IN_W = 33,
  parameter int unsigned W    = 16
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [W-1:0]    dout_c,
  output logic                   sat_c
);

  // Range limits expressed at the full input width so the compare never truncates.
  localparam logic signed [IN_W-1:0] MAXV = $signed({{(IN_W-W+1){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [IN_W-1:0] MINV = $signed({{(IN_W-W+1){1'b1}}, {(W-1){1'b0}}});

  always_comb begin
    dout_c = din[W-1:0];
    sat_c  = 1'b0;
    if (din > MAXV) begin
      dout_c = MAXV[W-1:0];
      sat_c  = 1'b1;
    end else if (din < MINV) begin
      dout_c = MINV[W-1:0];
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_alu_pipe.sv
// Two-stage fixed-point ALU (Q INT_BITS.FRAC_BITS) with saturating result
// and an internal MAC accumulator. Valid/ready handshake on both sides.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand beat handshake (in_ready is combinational)
//   a, b, op            - signed operands and operation code
//   out_valid, out_ready- result beat handshake
//   result, sat         - saturated result and clamp flag
module fxp_alu_pipe
  import fxp_pkg::*;
#(
  parameter  int unsigned INT_BITS  = DEF_INT_BITS,
  parameter  int unsigned FRAC_BITS = DEF_FRAC_BITS,
  parameter  int unsigned ROUND     = 0,
  localparam int unsigned W         = INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         sat
);

  // WW holds a full product (2W) plus one bit of rounding headroom.
  localparam int unsigned WW = 2 * W + 1;
  localparam int unsigned AW = WW + 1;
  localparam logic signed [WW-1:0] RND =
    (ROUND != 0) ? (WW'(1) << (FRAC_BITS - 1)) : '0;

  logic                 adv;
  logic                 s1_valid;
  logic [2:0]           s1_op;
  logic signed [WW-1:0] s1_wide;
  logic signed [WW-1:0] s1_wide_nxt;
  logic signed [WW-1:0] sa, sb;
  logic signed [W-1:0]  acc;
  logic signed [WW-1:0] scaled;
  logic signed [WW-1:0] res_wide;
  logic signed [AW-1:0] acc_wide;
  logic signed [W-1:0]  res_sat, acc_sat;
  logic                 res_clamp, acc_clamp;
  logic signed [W-1:0]  res_nxt, acc_nxt;
  logic                 sat_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign sa = WW'($signed(a));
  assign sb = WW'($signed(b));

  // Stage-1 datapath: full-precision sum/difference/product.
  always_comb begin
    s1_wide_nxt = '0;
    case (op)
      OP_ADD:         s1_wide_nxt = sa + sb;
      OP_SUB:         s1_wide_nxt = sa - sb;
      OP_MUL, OP_MAC: s1_wide_nxt = sa * sb;
      default:        s1_wide_nxt = '0;
    endcase
  end

  // Stage-2 scaling: arithmetic shift, optionally rounding half-up first.
  assign scaled   = (s1_wide + RND) >>> FRAC_BITS;
  assign res_wide = (s1_op == OP_MUL) ? scaled : s1_wide;
  assign acc_wide = AW'(acc) + AW'(scaled);

  fxp_sat #(.IN_W(WW), .W(W)) u_sat_res (
    .din    (res_wide),
    .dout_c (res_sat),
    .sat_c  (res_clamp)
  );

  fxp_sat #(.IN_W(AW), .W(W)) u_sat_acc (
    .din    (acc_wide),
    .dout_c (acc_sat),
    .sat_c  (acc_clamp)
  );

  // Stage-2 result/accumulator selection by op.
  always_comb begin
    res_nxt = '0;
    sat_nxt = 1'b0;
    acc_nxt = acc;
    case (s1_op)
      OP_ADD, OP_SUB, OP_MUL: begin
        res_nxt = res_sat;
        sat_nxt = res_clamp;
      end
      OP_MAC: begin
        res_nxt = acc_sat;
        sat_nxt = acc_clamp;
        acc_nxt = acc_sat;
      end
      OP_ACC_CLR: acc_nxt = '0;
      OP_ACC_RD:  res_nxt = acc;
      default:    res_nxt = '0;
    endcase
  end

  // Pipeline registers; everything holds when the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_wide   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_wide <= s1_wide_nxt;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_nxt;
        sat    <= sat_nxt;
        acc    <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// Directed bench for fxp_alu_pipe: default, round-half-up and Q4.12 builds
// share one stimulus stream; each is checked where its behaviour is distinct.
module tb_fxp_alu_pipe;
  import fxp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic [2:0]  op;

  logic        ir_d, ov_d, ss_d;
  logic [15:0] rs_d;
  logic        ir_r, ov_r, ss_r;
  logic [15:0] rs_r;
  logic        ir_s, ov_s, ss_s;
  logic [15:0] rs_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fxp_alu_pipe u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_d),
    .a(a), .b(b), .op(op), .out_valid(ov_d), .out_ready(out_ready),
    .result(rs_d), .sat(ss_d)
  );

  fxp_alu_pipe #(.ROUND(1)) u_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_r),
    .a(a), .b(b), .op(op), .out_valid(ov_r), .out_ready(out_ready),
    .result(rs_r), .sat(ss_r)
  );

  fxp_alu_pipe #(.INT_BITS(4), .FRAC_BITS(12)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s),
    .a(a), .b(b), .op(op), .out_valid(ov_s), .out_ready(out_ready),
    .result(rs_s), .sat(ss_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat; returns at the negedge where its result is presented.
  task automatic do_beat(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    logic got_v;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ov_d) begin
        got_v = 1'b1;
        break;
      end
    end
    chk("beat_valid", 32'(got_v), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_s [4];
  logic [15:0] held;
  logic        held_v;
  logic        take;
  int          sent, got;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = OP_ADD;
    exp_s[0] = 16'h0011; exp_s[1] = 16'h0021; exp_s[2] = 16'h0031; exp_s[3] = 16'h0041;

    // Reset state
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov_d), 32'd0);
    chk("rst_result",    32'(rs_d), 32'h0);
    chk("rst_sat",       32'(ss_d), 32'd0);
    chk("rst_in_ready",  32'(ir_d), 32'd1);

    // Add/sub saturation and plain add
    do_beat(OP_ADD, 16'h7F00, 16'h0200);
    chk("add_pos_sat_res", 32'(rs_d), 32'h7FFF);
    chk("add_pos_sat_flag", 32'(ss_d), 32'd1);
    do_beat(OP_SUB, 16'h8000, 16'h0100);
    chk("sub_neg_sat_res", 32'(rs_d), 32'h8000);
    chk("sub_neg_sat_flag", 32'(ss_d), 32'd1);
    do_beat(OP_ADD, 16'h0100, 16'h0080);
    chk("add_plain_res", 32'(rs_d), 32'h0180);
    chk("add_plain_flag", 32'(ss_d), 32'd0);

    // Multiply: exact, truncate vs round, saturate
    do_beat(OP_MUL, 16'h0180, 16'h0200);
    chk("mul_1p5x2_res", 32'(rs_d), 32'h0300);
    chk("mul_1p5x2_flag", 32'(ss_d), 32'd0);
    do_beat(OP_MUL, 16'h0001, 16'h0080);
    chk("mul_trunc_res", 32'(rs_d), 32'h0000);
    chk("mul_round_res", 32'(rs_r), 32'h0001);
    do_beat(OP_MUL, 16'h4000, 16'h0400);
    chk("mul_sat_res", 32'(rs_d), 32'h7FFF);
    chk("mul_sat_flag", 32'(ss_d), 32'd1);

    // Accumulator: clear then three back-to-back MACs
    do_beat(OP_ACC_CLR, 16'h1234, 16'h5678);
    chk("clr_res", 32'(rs_d), 32'h0);
    chk("clr_flag", 32'(ss_d), 32'd0);
    @(negedge clk);
    op = OP_MAC; a = 16'h0100; b = 16'h0200; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mac1_valid", 32'(ov_d), 32'd1);
    chk("mac1_res", 32'(rs_d), 32'h0200);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mac2_valid", 32'(ov_d), 32'd1);
    chk("mac2_res", 32'(rs_d), 32'h0400);
    @(negedge clk);
    chk("mac3_valid", 32'(ov_d), 32'd1);
    chk("mac3_res", 32'(rs_d), 32'h0600);
    do_beat(OP_ACC_RD, 16'h0000, 16'h0000);
    chk("acc_rd_res", 32'(rs_d), 32'h0600);
    chk("acc_rd_flag", 32'(ss_d), 32'd0);

    // Reserved op yields a zero beat and leaves acc alone
    do_beat(3'b110, 16'h1234, 16'h0100);
    chk("rsvd_res", 32'(rs_d), 32'h0);
    chk("rsvd_flag", 32'(ss_d), 32'd0);
    do_beat(OP_ACC_RD, 16'h0000, 16'h0000);
    chk("acc_after_rsvd", 32'(rs_d), 32'h0600);

    // Q4.12 build
    do_beat(OP_MUL, 16'h1000, 16'h1000);
    chk("q412_mul_res", 32'(rs_s), 32'h1000);
    chk("q412_mul_flag", 32'(ss_s), 32'd0);
    do_beat(OP_ADD, 16'h7000, 16'h7000);
    chk("q412_add_res", 32'(rs_s), 32'h7FFF);
    chk("q412_add_flag", 32'(ss_s), 32'd1);

    // 4-beat stream with a 3-cycle output stall
    sent = 0; got = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 4);
      op = OP_ADD; a = 16'(16'h0010 * (sent + 1)); b = 16'h0001;
      #1;
      if (ov_d && out_ready) begin
        chk("stream_order", 32'(rs_d), 32'(exp_s[got]));
        got++;
        held_v = 1'b0;
      end else if (ov_d) begin
        chk("stall_in_ready", 32'(ir_d), 32'd0);
        if (held_v) chk("stall_hold", 32'(rs_d), 32'(held));
        held   = rs_d;
        held_v = 1'b1;
      end
      take = in_valid && ir_d;
      @(posedge clk);
      if (take) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_got", 32'(got), 32'd4);
    chk("stream_sent", 32'(sent), 32'd4);
    @(negedge clk);
    chk("stream_no_dup", 32'(ov_d), 32'd0);

    // Reset with two beats in flight under stall
    @(negedge clk);
    out_ready = 1'b0; op = OP_ADD; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0002;
    @(negedge clk);
    chk("pre_rst_valid", 32'(ov_d), 32'd1);
    rst = 1'b1; op = OP_MAC; a = 16'h0100; b = 16'h0100;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_valid", 32'(ov_d), 32'd0);
    chk("post_rst_result", 32'(rs_d), 32'h0);
    chk("post_rst_in_ready", 32'(ir_d), 32'd1);
    @(negedge clk);
    chk("post_rst_no_ghost", 32'(ov_d), 32'd0);
    do_beat(OP_ACC_RD, 16'h0000, 16'h0000);
    chk("post_rst_acc", 32'(rs_d), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
